// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM between two masters (m0 = CPU control unit,
//   m1 = program loader/DMA). One access runs at a time. For reads, the
//   address and rden are held for RD_LATENCY cycles. q is captured one cycle
//   later and returned to the master that won the access.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   mX_req/we/addr/wdata       request from master X, held until mX_ack
//   mX_ack                     1-cycle pulse, request accepted
//   mX_rdata/mX_rvalid         read data, valid for one cycle with rvalid
//                              (rdata is held until that master's next read)
//   ram_address/data/rden/wren RAM control
//   ram_q                      RAM read data
//   busy                       an access is in progress
//   owner                      master of the current/last access (0=m0, 1=m1)
//
// Parameters
//   ADDR_W, DATA_W, RD_LATENCY (legal 1..7)
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: a tie goes to the master that did not win last.
//                       undefined: m0 always wins a tie.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | sampling requests, no RAM strobe
// WR      | one-cycle write strobe to the RAM
// RD_WAIT | rden + address held for RD_LATENCY cycles
// RD_CAP  | rden low, address held, ram_q captured at end of cycle

module ram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_CAP  = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic              any_req;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_comb begin
    any_req = m0_req | m1_req;
    // On a tie the master that did not win last time goes first.
    if (m0_req && m1_req) winner = ~last_owner;
    else                  winner = m1_req;
  end
`else
  always_comb begin
    any_req = m0_req | m1_req;
    winner  = m1_req & ~m0_req;
  end
`endif

  assign sel_we    = winner ? m1_we    : m0_we;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner  <= 1'b0;
`endif
    end else begin
      // Handshake pulses last exactly one cycle.
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= winner;
            ram_address <= sel_addr;
            ram_data    <= sel_wdata;
            cnt         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= winner;
`endif
            if (winner) m1_ack <= 1'b1;
            else        m0_ack <= 1'b1;
            if (sel_we) begin
              ram_wren <= 1'b1;
              state    <= WR;
            end else begin
              ram_rden <= 1'b1;
              state    <= RD_WAIT;
            end
          end
        end

        WR: begin
          ram_wren <= 1'b0;
          state    <= IDLE;
        end

        RD_WAIT: begin
          if (cnt == CNT_LAST) begin
            ram_rden <= 1'b0;
            state    <= RD_CAP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        RD_CAP: begin
          // Address is still held here, so ram_q belongs to this access.
          if (owner) begin
            m1_rdata  <= ram_q;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= ram_q;
            m0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          ram_rden <= 1'b0;
          ram_wren <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int L = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_data, ram_q;
  logic        ram_rden, ram_wren, busy, owner;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM environment: q is mem[address] delayed by two clocks.
  logic [7:0] ram_mem [0:65535];
  bit         ram_wr  [0:65535];
  logic [7:0] ram_p1;
  always @(posedge clk) begin
    if (ram_wren) begin
      ram_mem[ram_address] <= ram_data;
      ram_wr[ram_address]  <= 1'b1;
    end
    ram_p1 <= ram_wr[ram_address] ? ram_mem[ram_address] : init_val(ram_address);
    ram_q  <= ram_p1;
  end

  // Reference model: a transaction timeline of expected pulses per cycle.
  int          cyc = 0, free_at = 0;
  bit          last_own = 0, exp_owner = 0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_data = '0, exp_rd0 = '0, exp_rd1 = '0;
  bit          s_ack0[32], s_ack1[32], s_wren[32], s_rden[32], s_rv0[32], s_rv1[32];
  logic [7:0]  s_rvd[32];
  logic [7:0]  ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  int          n_checks = 0, n_pass = 0;

  // Stimulus state per master.
  bit          rq[2], rwe[2];
  logic [15:0] raddr[2];
  logic [7:0]  rdat[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [47:0] outs();
    return {m0_ack, m0_rvalid, m0_rdata, m1_ack, m1_rvalid, m1_rdata,
            ram_address, ram_data, ram_rden, ram_wren, busy, owner};
  endfunction

  task automatic clear_slot(input int s);
    s_ack0[s] = 0; s_ack1[s] = 0; s_wren[s] = 0; s_rden[s] = 0;
    s_rv0[s] = 0; s_rv1[s] = 0; s_rvd[s] = '0;
  endtask

  task automatic model_reset();
    free_at = 0; last_own = 0; exp_owner = 0;
    exp_addr = '0; exp_data = '0; exp_rd0 = '0; exp_rd1 = '0;
    for (int s = 0; s < 32; s++) clear_slot(s);
  endtask

  task automatic model_step();
    bit w, we;
    logic [15:0] a;
    logic [7:0] d;
    int n;
    cyc++;
    n = cyc;
    if (reset) model_reset();
    else if (free_at < n && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = RR ? ~last_own : 1'b0;
      else                  w = m1_req;
      we = w ? m1_we : m0_we;
      a  = w ? m1_addr : m0_addr;
      d  = w ? m1_wdata : m0_wdata;
      last_own = w; exp_owner = w; exp_addr = a; exp_data = d;
      if (w) s_ack1[n % 32] = 1; else s_ack0[n % 32] = 1;
      if (we) begin
        s_wren[n % 32] = 1;
        ref_mem[a] = d; ref_wr[a] = 1;
        free_at = n + 1;
      end else begin
        for (int k = 0; k < L; k++) s_rden[(n + k) % 32] = 1;
        if (w) s_rv1[(n + L + 1) % 32] = 1; else s_rv0[(n + L + 1) % 32] = 1;
        s_rvd[(n + L + 1) % 32] = ref_wr[a] ? ref_mem[a] : init_val(a);
        free_at = n + L + 1;
      end
    end
  endtask

  task automatic compare();
    int s;
    s = cyc % 32;
    if (s_rv0[s]) exp_rd0 = s_rvd[s];
    if (s_rv1[s]) exp_rd1 = s_rvd[s];
    chk("pulses ack0/ack1/wren/rden/rv0/rv1",
        {m0_ack, m1_ack, ram_wren, ram_rden, m0_rvalid, m1_rvalid},
        {s_ack0[s], s_ack1[s], s_wren[s], s_rden[s], s_rv0[s], s_rv1[s]});
    chk("ram_address", ram_address, exp_addr);
    chk("ram_data", ram_data, exp_data);
    chk("busy/owner", {busy, owner}, {(cyc < free_at), exp_owner});
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
    clear_slot(s);
  endtask

  task automatic apply();
    m0_req = rq[0]; m0_we = rwe[0]; m0_addr = raddr[0]; m0_wdata = rdat[0];
    m1_req = rq[1]; m1_we = rwe[1]; m1_addr = raddr[1]; m1_wdata = rdat[1];
  endtask

  task automatic set_req(input int i, input bit we, input logic [15:0] a, input logic [7:0] d);
    rq[i] = 1; rwe[i] = we; raddr[i] = a; rdat[i] = d;
  endtask

  task automatic new_rand_req(input int i);
    logic [15:0] a;
    a = 16'h1200 + 16'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) a = 16'($urandom);
    set_req(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  task automatic quiesce();
    @(negedge clk);
    rq[0] = 0; rq[1] = 0;
    apply();
    repeat (12) @(negedge clk);
    chk("quiesce busy", busy, 1'b0);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        model_step();
        #1;
        compare();
      end
      begin
        #1_000_000;
        chk("watchdog timeout", 1'b0, 1'b1);
      end
      begin : main_seq
        int fa[2], fr[2], na[2], nr[2], ea[2], er[2], g[6];
        int ng, nrv, fw, sw;

        for (int i = 0; i < 2; i++) begin
          rq[i] = 0; rwe[i] = 0; raddr[i] = '0; rdat[i] = '0;
        end
        apply();
        repeat (2) @(posedge clk);
        #2 chk("reset state", outs(), 48'h0);
        @(negedge clk);
        reset = 1'b0;
        quiesce();

        // m0 write 1234 <- A5
        @(negedge clk); set_req(0, 1'b1, 16'h1234, 8'hA5); apply();
        @(posedge clk); #2;
        chk("t2 write cycle1", {m0_ack, m1_ack, ram_wren, ram_rden, ram_address, ram_data, owner},
            {1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0});
        @(negedge clk); rq[0] = 0; apply();
        @(posedge clk); #2;
        chk("t2 wren drop", {ram_wren, busy}, 2'b00);

        // m1 write 1235 <- 3C
        @(negedge clk); set_req(1, 1'b1, 16'h1235, 8'h3C); apply();
        @(posedge clk); #2;
        chk("t2b m1 write", {m1_ack, m0_ack, owner, ram_wren, ram_address, ram_data},
            {1'b1, 1'b0, 1'b1, 1'b1, 16'h1235, 8'h3C});
        @(negedge clk); rq[1] = 0; apply();

        // m0 read 1234
        @(negedge clk); set_req(0, 1'b0, 16'h1234, 8'h00); apply();
        @(posedge clk); #2;
        chk("t3 c1 ack+rden", {m0_ack, ram_rden, ram_wren}, 3'b110);
        @(negedge clk); rq[0] = 0; apply();
        @(posedge clk); #2;
        chk("t3 c2 rden", {ram_rden, m0_rvalid}, 2'b10);
        @(posedge clk); #2;
        chk("t3 c3 capture", {ram_rden, busy, m0_rvalid, ram_address}, {3'b010, 16'h1234});
        @(posedge clk); #2;
        chk("t3 c4 rvalid", {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, 8'hA5});

        // simultaneous reads
        quiesce();
        @(negedge clk);
        set_req(0, 1'b0, 16'h1234, 8'h00);
        set_req(1, 1'b0, 16'h1235, 8'h00);
        apply();
        for (int i = 0; i < 2; i++) begin fa[i] = -1; fr[i] = -1; na[i] = 0; nr[i] = 0; end
        for (int c = 1; c <= 12; c++) begin
          @(posedge clk); #2;
          if (m0_ack)    begin na[0]++; if (fa[0] < 0) fa[0] = c; end
          if (m1_ack)    begin na[1]++; if (fa[1] < 0) fa[1] = c; end
          if (m0_rvalid) begin nr[0]++; if (fr[0] < 0) fr[0] = c; end
          if (m1_rvalid) begin nr[1]++; if (fr[1] < 0) fr[1] = c; end
          @(negedge clk);
          if (m0_ack) rq[0] = 0;
          if (m1_ack) rq[1] = 0;
          apply();
        end
        fw = RR ? 1 : 0;
        sw = 1 - fw;
        ea[fw] = 1;     er[fw] = L + 2;
        ea[sw] = L + 3; er[sw] = 2 * L + 4;
        chk("t4 m0 ack cycle", fa[0], ea[0]);
        chk("t4 m1 ack cycle", fa[1], ea[1]);
        chk("t4 m0 rvalid cycle", fr[0], er[0]);
        chk("t4 m1 rvalid cycle", fr[1], er[1]);
        chk("t4 pulse counts", {na[0][3:0], na[1][3:0], nr[0][3:0], nr[1][3:0]}, 16'h1111);
        chk("t4 read data", {m0_rdata, m1_rdata}, 16'hA53C);

        // both hold write requests continuously for six accesses
        quiesce();
        @(negedge clk);
        set_req(0, 1'b1, 16'h2000, 8'h11);
        set_req(1, 1'b1, 16'h2001, 8'h22);
        apply();
        for (int i = 0; i < 6; i++) g[i] = -1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
          @(posedge clk); #2;
          if (m0_ack && ng < 6) begin g[ng] = 0; ng++; end
          if (m1_ack && ng < 6) begin g[ng] = 1; ng++; end
        end
        @(negedge clk); rq[0] = 0; rq[1] = 0; apply();
        chk("t5 grant count", ng, 6);
        for (int i = 0; i < 6; i++)
          chk($sformatf("t5 grant %0d", i), g[i], RR ? ((i % 2 == 0) ? 1 : 0) : 0);

        // reset during an m1 read
        quiesce();
        @(negedge clk); set_req(1, 1'b0, 16'h1235, 8'h00); apply();
        @(posedge clk); #2;
        chk("t6 ack", {m1_ack, ram_rden}, 2'b11);
        @(negedge clk); rq[1] = 0; apply();
        @(posedge clk); #2;
        chk("t6 rd_wait", {busy, ram_rden}, 2'b11);
        @(negedge clk); reset = 1'b1;
        #1 chk("t6 reset outputs", outs(), 48'h0);
        @(negedge clk); reset = 1'b0;
        nrv = 0;
        repeat (8) begin
          @(posedge clk); #2;
          if (m1_rvalid || m0_rvalid || m0_ack || m1_ack) nrv++;
        end
        chk("t6 no spurious pulse", nrv, 0);
        @(negedge clk); set_req(1, 1'b0, 16'h1235, 8'h00); apply();
        @(posedge clk); #2;
        chk("t6 reread ack", m1_ack, 1'b1);
        @(negedge clk); rq[1] = 0; apply();
        repeat (2) @(posedge clk);
        @(posedge clk); #2;
        chk("t6 reread data", {m1_rvalid, m1_rdata}, {1'b1, 8'h3C});

        // randomized traffic with a reset in the middle
        quiesce();
        for (int it = 0; it < 1500; it++) begin
          @(negedge clk);
          for (int i = 0; i < 2; i++) begin
            if (rq[i]) begin
              if (i == 0 ? m0_ack : m1_ack) begin
                if ($urandom_range(0, 3) == 0) new_rand_req(i);
                else rq[i] = 0;
              end
            end else if ($urandom_range(0, 2) == 0) begin
              new_rand_req(i);
            end
          end
          apply();
          if (it == 700) begin
            reset = 1'b1;
            #1 chk("t1 reset mid-run outputs", outs(), 48'h0);
          end else if (it == 703) begin
            reset = 1'b0;
          end
        end
        quiesce();
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
